// File: rtl/timer_defs_pkg.sv
// Shared definitions for the mm:ss countdown timer: state encoding, BCD limits
// and the four-digit count payload.
package timer_defs_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [DIGIT_W-1:0] BCD_MAX_ONES = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MAX_TENS = 4'd5;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } mmss_t;

endpackage

// File: rtl/bcd_mmss_dec.sv
// Combinational one-second decrement of an mm:ss BCD count with a zero flag.
// A 00:00 input passes through unchanged so the count never wraps.
module bcd_mmss_dec
  import timer_defs_pkg::*;
(
  input  mmss_t cnt_in,
  output mmss_t cnt_dec,
  output logic  is_zero
);

  // Borrow ripples sec_ones -> sec_tens -> min_ones -> min_tens.
  always_comb begin
    cnt_dec = cnt_in;
    is_zero = (cnt_in == '0);
    if (!is_zero) begin
      if (cnt_in.sec_ones != '0) begin
        cnt_dec.sec_ones = cnt_in.sec_ones - DIGIT_W'(1);
      end else begin
        cnt_dec.sec_ones = BCD_MAX_ONES;
        if (cnt_in.sec_tens != '0) begin
          cnt_dec.sec_tens = cnt_in.sec_tens - DIGIT_W'(1);
        end else begin
          cnt_dec.sec_tens = BCD_MAX_TENS;
          if (cnt_in.min_ones != '0) begin
            cnt_dec.min_ones = cnt_in.min_ones - DIGIT_W'(1);
          end else begin
            cnt_dec.min_ones = BCD_MAX_ONES;
            cnt_dec.min_tens = cnt_in.min_tens - DIGIT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/countdown_timer_core.sv
// mm:ss countdown timer: loads a sanitised BCD preset, counts down once per
// _1Hzclk edge and holds an alarm for ALARM_CYCLES edges at 00:00.
module countdown_timer_core
  import timer_defs_pkg::*;
#(
  parameter int unsigned ALARM_CYCLES = 5,
  parameter int unsigned CNT_W        = 4
) (
  input  logic                _1Hzclk,
  input  logic                init_rst,
  input  logic                stsp_sign,
  input  logic                set_sign,
  input  logic [2*DIGIT_W-1:0] preset_min,
  input  logic [2*DIGIT_W-1:0] preset_sec,
  output logic [DIGIT_W-1:0]  min_tens,
  output logic [DIGIT_W-1:0]  min_ones,
  output logic [DIGIT_W-1:0]  sec_tens,
  output logic [DIGIT_W-1:0]  sec_ones,
  output logic                run_state,
  output logic                alarm
);

  localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_CYCLES - 1);

  state_t            state, state_nxt;
  mmss_t             cnt, cnt_nxt, cnt_dec, preset_c;
  logic              cnt_zero;
  logic [CNT_W-1:0]  alarm_cnt, alarm_cnt_nxt;

  bcd_mmss_dec u_dec (
    .cnt_in  (cnt),
    .cnt_dec (cnt_dec),
    .is_zero (cnt_zero)
  );

  // Clamp out-of-range preset digits to the largest legal value.
  always_comb begin
    preset_c.min_tens = (preset_min[7:4] > BCD_MAX_TENS) ? BCD_MAX_TENS : preset_min[7:4];
    preset_c.min_ones = (preset_min[3:0] > BCD_MAX_ONES) ? BCD_MAX_ONES : preset_min[3:0];
    preset_c.sec_tens = (preset_sec[7:4] > BCD_MAX_TENS) ? BCD_MAX_TENS : preset_sec[7:4];
    preset_c.sec_ones = (preset_sec[3:0] > BCD_MAX_ONES) ? BCD_MAX_ONES : preset_sec[3:0];
  end

  // Next state / count; set_sign takes priority over stsp_sign in every state.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    alarm_cnt_nxt = alarm_cnt;
    case (state)
      IDLE: begin
        if (set_sign) begin
          cnt_nxt = preset_c;
        end else if (stsp_sign && !cnt_zero) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (set_sign) begin
          cnt_nxt   = preset_c;
          state_nxt = IDLE;
        end else if (stsp_sign) begin
          state_nxt = PAUSE;
        end else begin
          cnt_nxt = cnt_dec;
          if (cnt_dec == '0) begin
            state_nxt     = DONE;
            alarm_cnt_nxt = '0;
          end
        end
      end
      PAUSE: begin
        if (set_sign) begin
          cnt_nxt   = preset_c;
          state_nxt = IDLE;
        end else if (stsp_sign) begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        if (set_sign) begin
          cnt_nxt   = preset_c;
          state_nxt = IDLE;
        end else if (stsp_sign || (alarm_cnt == ALARM_LAST)) begin
          state_nxt = IDLE;
        end else begin
          alarm_cnt_nxt = alarm_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they track state exactly.
  always_ff @(posedge _1Hzclk or negedge init_rst) begin
    if (!init_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      alarm_cnt <= '0;
      run_state <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      alarm_cnt <= alarm_cnt_nxt;
      run_state <= (state_nxt == RUN);
      alarm     <= (state_nxt == DONE);
    end
  end

  assign min_tens = cnt.min_tens;
  assign min_ones = cnt.min_ones;
  assign sec_tens = cnt.sec_tens;
  assign sec_ones = cnt.sec_ones;

endmodule

// File: tb/tb_countdown_timer_core.sv
// Bench for countdown_timer_core: directed scenarios plus random pulses, checked
// against a model that keeps the count as total seconds.
module tb_countdown_timer_core;

  localparam int ALARM = 5;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       _1Hzclk = 1'b0;
  logic       init_rst = 1'b0;
  logic       stsp_sign = 1'b0;
  logic       set_sign = 1'b0;
  logic [7:0] preset_min = 8'h00;
  logic [7:0] preset_sec = 8'h00;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       run_state, alarm;

  int n_tests = 0;
  int n_fail  = 0;

  // model: total seconds remaining, coarse mode, alarm cycles left
  int m_secs  = 0;
  int m_state = M_IDLE;
  int m_left  = 0;

  countdown_timer_core #(.ALARM_CYCLES(ALARM), .CNT_W(4)) dut (
    ._1Hzclk    (_1Hzclk),
    .init_rst   (init_rst),
    .stsp_sign  (stsp_sign),
    .set_sign   (set_sign),
    .preset_min (preset_min),
    .preset_sec (preset_sec),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .run_state  (run_state),
    .alarm      (alarm)
  );

  always #5 _1Hzclk = ~_1Hzclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  function automatic logic [15:0] model_digits();
    int m, s;
    m = m_secs / 60;
    s = m_secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int preset_secs(input logic [7:0] pm, input logic [7:0] ps);
    int mt, mo, st, so;
    mt = (int'(pm[7:4]) > 5) ? 5 : int'(pm[7:4]);
    mo = (int'(pm[3:0]) > 9) ? 9 : int'(pm[3:0]);
    st = (int'(ps[7:4]) > 5) ? 5 : int'(ps[7:4]);
    so = (int'(ps[3:0]) > 9) ? 9 : int'(ps[3:0]);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  task automatic model_edge(input logic st, input logic ss, input logic [7:0] pm, input logic [7:0] ps);
    if (st) begin
      m_secs  = preset_secs(pm, ps);
      m_state = M_IDLE;
    end else begin
      case (m_state)
        M_IDLE:  if (ss && m_secs != 0) m_state = M_RUN;
        M_RUN: begin
          if (ss) m_state = M_PAUSE;
          else begin
            m_secs--;
            if (m_secs == 0) begin
              m_state = M_DONE;
              m_left  = ALARM;
            end
          end
        end
        M_PAUSE: if (ss) m_state = M_RUN;
        default: begin
          m_left--;
          if (ss || m_left == 0) m_state = M_IDLE;
        end
      endcase
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".digits"}, 32'(digits()), 32'(model_digits()));
    check({tag, ".run_state"}, 32'(run_state), 32'(m_state == M_RUN));
    check({tag, ".alarm"}, 32'(alarm), 32'(m_state == M_DONE));
  endtask

  // One clock edge with the given pulses; checked 1 time unit after the edge.
  task automatic step(input logic st, input logic ss, input logic [7:0] pm, input logic [7:0] ps);
    set_sign   = st;
    stsp_sign  = ss;
    preset_min = pm;
    preset_sec = ps;
    @(posedge _1Hzclk);
    #1;
    set_sign  = 1'b0;
    stsp_sign = 1'b0;
    model_edge(st, ss, pm, ps);
    compare_model("step");
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset();
    init_rst = 1'b0;
    #1;
    m_secs  = 0;
    m_state = M_IDLE;
    m_left  = 0;
    compare_model("reset");
    #1;
    init_rst = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();

    // 01:05 load, start, borrow across the minute
    step(1'b1, 1'b0, 8'h01, 8'h05);
    check("load_0105", 32'(digits()), 32'h0105);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    check("start_run", 32'(run_state), 32'd1);
    idle_steps(5);
    check("at_0100", 32'(digits()), 32'h0100);
    idle_steps(1);
    check("at_0059", 32'(digits()), 32'h0059);

    // 00:03 to alarm, alarm held ALARM edges then auto-return
    step(1'b1, 1'b0, 8'h00, 8'h03);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    idle_steps(3);
    check("alarm_on", 32'(alarm), 32'd1);
    idle_steps(ALARM - 1);
    check("alarm_held", 32'(alarm), 32'd1);
    idle_steps(1);
    check("alarm_off", 32'(alarm), 32'd0);
    check("done_count", 32'(digits()), 32'h0000);

    // pause and resume
    step(1'b1, 1'b0, 8'h10, 8'h00);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    idle_steps(2);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    idle_steps(10);
    check("paused", 32'(digits()), 32'h0958);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    idle_steps(1);
    check("resumed", 32'(digits()), 32'h0957);

    // sanitising and start ignored at 00:00
    step(1'b1, 1'b0, 8'h7A, 8'h6F);
    check("sanitise", 32'(digits()), 32'h5959);
    @(negedge _1Hzclk);
    do_reset();
    step(1'b0, 1'b1, 8'h00, 8'h00);
    check("zero_start", 32'(run_state), 32'd0);

    // set beats start in RUN; start acknowledges DONE
    step(1'b1, 1'b0, 8'h04, 8'h21);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    idle_steps(1);
    step(1'b1, 1'b1, 8'h02, 8'h00);
    check("set_prio", 32'(digits()), 32'h0200);
    step(1'b1, 1'b0, 8'h00, 8'h01);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    idle_steps(1);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    check("ack_alarm", 32'(alarm), 32'd0);

    // async reset mid-RUN
    step(1'b1, 1'b0, 8'h03, 8'h34);
    step(1'b0, 1'b1, 8'h00, 8'h00);
    idle_steps(1);
    do_reset();
    check("reset_run", 32'(run_state), 32'd0);

    // randomised pulses and presets
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        do_reset();
      end else begin
        step(r < 9, ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00, 8'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
